ahb_slave_reg_decoder: RTL and testbench
========================================

Name: ahb_slave_reg_decoder

Overview:
AHB-Lite slave-side data-phase decoder for the USB endpoint register map. It is the parametrised successor to the fixed 7-bit single-mode address decoder. It registers the address phase and validates size and alignment. It generates OKAY or two-cycle ERROR responses, inserts wait states for buffer reads, and owns the endpoint-to-host transfer size (EHTS) register. It sits between the AHB-Lite bus and the endpoint data buffer and status/error logic.

Parameters:
ADDR_W, 7, haddr width; register block sits at fixed offsets 0x40-0x48 within this space.
BUF_BYTES, 64, data buffer window size; addresses 0..BUF_BYTES-1 map to the buffer; power of 2, at most 64.
LANE_MODE, 1, 0 = legacy right-justified read/write data; 1 = AHB little-endian byte lanes selected by haddr[1:0].
BO_W, 7, width of the buffer occupancy input, at most 8.

Ports:
clk  in  1  system clock
nRst  in  1  async active-low reset
hsel  in  1  slave select
haddr  in  ADDR_W  address phase address
htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ
hwrite  in  1  1 = write
hsize  in  2  0 byte, 1 half, 2 word, 3 illegal
hwdata  in  32  write data (data phase)
hrdata  out  32  read data
hready  out  1  transfer done / address accepted
hresp  out  1  1 = ERROR
status_data  in  16  status register (read-only)
error_data  in  16  error register (read-only)
bo_data  in  BO_W  buffer occupancy (read-only)
err_rd_ack  out  1  one-cycle pulse when an error register read completes
buf_rd_en  out  1  buffer read strobe
buf_wr_en  out  1  buffer write strobe
buf_addr  out  ADDR_W  buffer address (registered haddr)
buf_size  out  2  registered hsize
buf_wdata  out  32  write data, right-justified
buf_rdata  in  32  buffer read data, right-justified, valid the cycle after buf_rd_en
ehts  out  8  EHTS register value

Behaviour:
- Reset: state IDLE; hready=1, hresp=0, hrdata=0, all strobes 0, ehts=0, registered addr/size/write=0. Asserting reset mid-transfer aborts it; no strobe follows.
- Address phase is accepted only when hready=1 && hsel && htrans[1]. It captures addr, size and write, and decodes the next state. Otherwise the next state is IDLE.
- Legality: hsize=3 → ERR. Half with addr[0]=1 → ERR. Word with addr[1:0]≠0 → ERR. Unmapped address → ERR.
- Register access legality:
  - Status at 0x40/0x41 and error at 0x42/0x43: byte or half only, read-only.
  - BO at 0x44: byte read only.
  - EHTS at 0x48: byte read or write.
  - Any other size or a write to a read-only register → ERR.
- States: IDLE, WRITE, REG_READ, BUF_WAIT, BUF_READ, ERR1, ERR2.
- WRITE: hready=1, 0 wait.
  - Buffer target: buf_wr_en=1 for this cycle. buf_wdata = selected lane(s) of hwdata, right-justified and zero-extended (LANE_MODE=0: hwdata low bits).
  - EHTS target: ehts ← lane byte at the next edge.
- REG_READ: hready=1, 0 wait.
  - hrdata holds the register value, zero-extended. With LANE_MODE=1 the value is shifted to byte lane addr[1:0].
  - Example: status half at 0x40 → hrdata[15:0]; error half at 0x42 → hrdata[31:16] (mode 0: [15:0]).
  - Error register read completing → err_rd_ack=1 for that cycle.
- BUF_WAIT: buf_rd_en=1, hready=0, then → BUF_READ.
- BUF_READ: hready=1. hrdata = buf_rdata masked to size and placed in lanes as above. A new address phase may be accepted in this cycle.
- ERR1: hready=0, hresp=1. ERR2: hready=1, hresp=1; a new address phase may be accepted.
- hrdata=0 in all states other than REG_READ and BUF_READ.
- Back-to-back: an EHTS write followed immediately by an EHTS read returns the new value. Strobes are never asserted in ERR states.
- hsel or htrans falling during wait states has no effect; the master holds the address phase by AHB rule.

Test Plan:
1. Reset with nRst low, then release → hready=1, hresp=0, hrdata=0, ehts=0.
2. Word write 0xDEADBEEF to 0x04, then word read 0x04 with buf_rdata=0xDEADBEEF → buf_wr_en pulse with buf_wdata=0xDEADBEEF; read shows one wait cycle (hready=0, buf_rd_en=1) then hrdata=0xDEADBEEF.
3. LANE_MODE=1, status_data=0xA55A: byte read 0x41 → hrdata=0x0000A500. Half read 0x40 → 0x0000A55A. LANE_MODE=0, byte read 0x41 → 0x000000A5.
4. Byte write 0x3C to 0x48, then byte read 0x48 back-to-back → ehts=0x3C after the write; read hrdata=0x3C (mode 1), no wait states.
5. Half write to 0x40, word read at 0x42, half read at 0x05, address 0x50 → each gives ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); no strobes; ehts unchanged.
6. Half read of 0x42 → err_rd_ack is a single-cycle pulse. Assert nRst during BUF_WAIT → all outputs take reset values immediately; no buf_rd_en follows.

Source files
------------

// File: rtl/ahb_slave_reg_decoder.sv
// rtl/ahb_slave_reg_decoder.sv - AHB-Lite data-phase decoder for the USB endpoint register map
module ahb_slave_reg_decoder #(
    parameter int ADDR_W    = 7,
    parameter int BUF_BYTES = 64,
    parameter int LANE_MODE = 1,
    parameter int BO_W      = 7
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [1:0]        hsize,
    input  logic [31:0]       hwdata,
    output logic [31:0]       hrdata,
    output logic              hready,
    output logic              hresp,
    input  logic [15:0]       status_data,
    input  logic [15:0]       error_data,
    input  logic [BO_W-1:0]   bo_data,
    output logic              err_rd_ack,
    output logic              buf_rd_en,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [1:0]        buf_size,
    output logic [31:0]       buf_wdata,
    input  logic [31:0]       buf_rdata,
    output logic [7:0]        ehts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_REG_READ,
        S_BUF_WAIT,
        S_BUF_READ,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [ADDR_W-1:0] BUF_LIM = ADDR_W'(BUF_BYTES);
    localparam logic [ADDR_W-1:0] A_STAT0 = ADDR_W'(7'h40);
    localparam logic [ADDR_W-1:0] A_STAT1 = ADDR_W'(7'h41);
    localparam logic [ADDR_W-1:0] A_ERR0  = ADDR_W'(7'h42);
    localparam logic [ADDR_W-1:0] A_ERR1  = ADDR_W'(7'h43);
    localparam logic [ADDR_W-1:0] A_BO    = ADDR_W'(7'h44);
    localparam logic [ADDR_W-1:0] A_EHTS  = ADDR_W'(7'h48);

    state_t            state;
    state_t            next_dec;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              accept;
    logic              is_buf_q;
    logic [4:0]        shamt;
    logic [31:0]       size_mask;
    logic [31:0]       reg_word;
    logic [31:0]       rd_rj;
    logic [7:0]        bo8;

    // Address phase is taken only while the bus sees us ready and a real transfer is requested
    assign accept = hready && hsel && (htrans == 2'b10 || htrans == 2'b11);

    // Decode the captured address phase into the next state, trapping every illegal access
    always_comb begin
        next_dec = S_ERR1;
        if (hsize == 2'd3) begin
            next_dec = S_ERR1;
        end else if (hsize == 2'd1 && haddr[0]) begin
            next_dec = S_ERR1;
        end else if (hsize == 2'd2 && haddr[1:0] != 2'b00) begin
            next_dec = S_ERR1;
        end else if (haddr < BUF_LIM) begin
            next_dec = hwrite ? S_WRITE : S_BUF_WAIT;
        end else if (haddr == A_STAT0 || haddr == A_STAT1 ||
                     haddr == A_ERR0  || haddr == A_ERR1) begin
            if (hsize != 2'd2 && !hwrite) next_dec = S_REG_READ;
        end else if (haddr == A_BO) begin
            if (hsize == 2'd0 && !hwrite) next_dec = S_REG_READ;
        end else if (haddr == A_EHTS && hsize == 2'd0) begin
            next_dec = hwrite ? S_WRITE : S_REG_READ;
        end
    end

    // Transfer FSM, captured address phase and the EHTS register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            ehts    <= 8'd0;
        end else begin
            if (state == S_WRITE && addr_q == A_EHTS) ehts <= buf_wdata[7:0];
            case (state)
                S_BUF_WAIT: state <= S_BUF_READ;
                S_ERR1:     state <= S_ERR2;
                default: begin
                    if (accept) begin
                        state   <= next_dec;
                        addr_q  <= haddr;
                        size_q  <= hsize;
                        write_q <= hwrite;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign is_buf_q = (addr_q < BUF_LIM);
    assign shamt    = {addr_q[1:0], 3'b000};
    assign bo8      = 8'(bo_data);

    // Byte-enable mask for the captured transfer size
    always_comb begin
        case (size_q)
            2'd0:    size_mask = 32'h0000_00FF;
            2'd1:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    end

    // Word-aligned view of the register block, as it would sit on the bus lanes
    always_comb begin
        reg_word = 32'd0;
        if (addr_q == A_STAT0 || addr_q == A_STAT1 || addr_q == A_ERR0 || addr_q == A_ERR1)
            reg_word = {error_data, status_data};
        else if (addr_q == A_BO)
            reg_word = {24'd0, bo8};
        else if (addr_q == A_EHTS)
            reg_word = {24'd0, ehts};
    end

    // Right-justified read value, then placed on its byte lanes when lane mode is on
    always_comb begin
        if (state == S_BUF_READ)
            rd_rj = buf_rdata & size_mask;
        else
            rd_rj = (reg_word >> shamt) & size_mask;
        hrdata = 32'd0;
        if (state == S_REG_READ || state == S_BUF_READ)
            hrdata = (LANE_MODE != 0) ? (rd_rj << shamt) : rd_rj;
    end

    // Write data extracted from the addressed lanes and right-justified
    always_comb begin
        if (LANE_MODE != 0)
            buf_wdata = (hwdata >> shamt) & size_mask;
        else
            buf_wdata = hwdata & size_mask;
    end

    // Handshake and strobes decoded from the current state
    always_comb begin
        hready     = !(state == S_BUF_WAIT || state == S_ERR1);
        hresp      = (state == S_ERR1 || state == S_ERR2);
        buf_rd_en  = (state == S_BUF_WAIT);
        buf_wr_en  = (state == S_WRITE) && write_q && is_buf_q;
        err_rd_ack = (state == S_REG_READ) && (addr_q == A_ERR0 || addr_q == A_ERR1);
    end

    assign buf_addr = addr_q;
    assign buf_size = size_q;

endmodule

// File: tb/tb_ahb_slave_reg_decoder.sv
// tb/tb_ahb_slave_reg_decoder.sv - directed self-checking bench for ahb_slave_reg_decoder
module tb_ahb_slave_reg_decoder;

    logic        clk = 1'b0;
    logic        nRst;
    logic        hsel;
    logic [6:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [1:0]  hsize;
    logic [31:0] hwdata;
    logic [15:0] status_data;
    logic [15:0] error_data;
    logic [6:0]  bo_data;
    logic [31:0] buf_rdata;

    logic [31:0] hrdata,    hrdata_m0;
    logic        hready,    hready_m0;
    logic        hresp,     hresp_m0;
    logic        err_rd_ack, err_rd_ack_m0;
    logic        buf_rd_en, buf_rd_en_m0;
    logic        buf_wr_en, buf_wr_en_m0;
    logic [6:0]  buf_addr,  buf_addr_m0;
    logic [1:0]  buf_size,  buf_size_m0;
    logic [31:0] buf_wdata, buf_wdata_m0;
    logic [7:0]  ehts,      ehts_m0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ahb_slave_reg_decoder #(.ADDR_W(7), .BUF_BYTES(64), .LANE_MODE(1), .BO_W(7)) dut (
        .clk(clk), .nRst(nRst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .status_data(status_data),
        .error_data(error_data), .bo_data(bo_data), .err_rd_ack(err_rd_ack),
        .buf_rd_en(buf_rd_en), .buf_wr_en(buf_wr_en), .buf_addr(buf_addr),
        .buf_size(buf_size), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .ehts(ehts)
    );

    ahb_slave_reg_decoder #(.ADDR_W(7), .BUF_BYTES(64), .LANE_MODE(0), .BO_W(7)) dut_m0 (
        .clk(clk), .nRst(nRst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata_m0),
        .hready(hready_m0), .hresp(hresp_m0), .status_data(status_data),
        .error_data(error_data), .bo_data(bo_data), .err_rd_ack(err_rd_ack_m0),
        .buf_rd_en(buf_rd_en_m0), .buf_wr_en(buf_wr_en_m0), .buf_addr(buf_addr_m0),
        .buf_size(buf_size_m0), .buf_wdata(buf_wdata_m0), .buf_rdata(buf_rdata),
        .ehts(ehts_m0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ap(input logic [6:0] a, input logic w, input logic [1:0] s);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    logic [6:0] err_addr  [4] = '{7'h40, 7'h42, 7'h05, 7'h50};
    logic       err_write [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] err_size  [4] = '{2'd1, 2'd2, 2'd1, 2'd0};

    initial begin
        nRst = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 2'd0; hwdata = '0; status_data = '0; error_data = '0;
        bo_data = '0; buf_rdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_hready", {31'd0, hready}, 32'd1);
        chk("rst_hresp",  {31'd0, hresp},  32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_ehts",   {24'd0, ehts}, 32'd0);
        nRst = 1'b1;

        // Buffer word write then word read with one wait state
        @(negedge clk); ap(7'h04, 1'b1, 2'd2);
        @(negedge clk); hwdata = 32'hDEADBEEF; ap(7'h04, 1'b0, 2'd2); #1;
        chk("wr_en",     {31'd0, buf_wr_en}, 32'd1);
        chk("wr_wdata",  buf_wdata, 32'hDEADBEEF);
        chk("wr_hready", {31'd0, hready}, 32'd1);
        chk("wr_addr",   {25'd0, buf_addr}, 32'h04);
        @(negedge clk); idle(); buf_rdata = 32'hDEADBEEF; #1;
        chk("rdw_hready", {31'd0, hready}, 32'd0);
        chk("rdw_rd_en",  {31'd0, buf_rd_en}, 32'd1);
        chk("rdw_hrdata", hrdata, 32'd0);
        @(negedge clk); #1;
        chk("rd_hready", {31'd0, hready}, 32'd1);
        chk("rd_hrdata", hrdata, 32'hDEADBEEF);

        // Status register lane placement in both modes
        @(negedge clk); status_data = 16'hA55A; ap(7'h41, 1'b0, 2'd0);
        @(negedge clk); idle(); #1;
        chk("st_byte_m1", hrdata,    32'h0000A500);
        chk("st_byte_m0", hrdata_m0, 32'h000000A5);
        @(negedge clk); ap(7'h40, 1'b0, 2'd1);
        @(negedge clk); idle(); #1;
        chk("st_half_m1", hrdata,    32'h0000A55A);
        chk("st_half_m0", hrdata_m0, 32'h0000A55A);

        // Buffer occupancy byte read
        @(negedge clk); bo_data = 7'h55; ap(7'h44, 1'b0, 2'd0);
        @(negedge clk); idle(); #1;
        chk("bo_read", hrdata, 32'h00000055);

        // EHTS write followed directly by a read
        @(negedge clk); ap(7'h48, 1'b1, 2'd0);
        @(negedge clk); hwdata = 32'h0000003C; ap(7'h48, 1'b0, 2'd0); #1;
        chk("ehts_wr_hready", {31'd0, hready}, 32'd1);
        chk("ehts_wr_noen",   {31'd0, buf_wr_en}, 32'd0);
        @(negedge clk); idle(); #1;
        chk("ehts_val",      {24'd0, ehts}, 32'h3C);
        chk("ehts_rd",       hrdata, 32'h0000003C);
        chk("ehts_rd_ready", {31'd0, hready}, 32'd1);

        // Illegal accesses produce the two-cycle error response without strobes
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ap(err_addr[i], err_write[i], err_size[i]);
            @(negedge clk); idle(); #1;
            chk($sformatf("err%0d_c1_hready", i), {31'd0, hready}, 32'd0);
            chk($sformatf("err%0d_c1_hresp", i),  {31'd0, hresp},  32'd1);
            chk($sformatf("err%0d_c1_strb", i),   {29'd0, buf_wr_en, buf_rd_en, err_rd_ack}, 32'd0);
            @(negedge clk); #1;
            chk($sformatf("err%0d_c2_hready", i), {31'd0, hready}, 32'd1);
            chk($sformatf("err%0d_c2_hresp", i),  {31'd0, hresp},  32'd1);
            chk($sformatf("err%0d_c2_strb", i),   {29'd0, buf_wr_en, buf_rd_en, err_rd_ack}, 32'd0);
            @(negedge clk); #1;
            chk($sformatf("err%0d_done_hresp", i), {31'd0, hresp}, 32'd0);
        end
        chk("err_ehts_kept", {24'd0, ehts}, 32'h3C);

        // Error register read acknowledge pulse
        @(negedge clk); error_data = 16'h1234; ap(7'h42, 1'b0, 2'd1);
        @(negedge clk); idle(); #1;
        chk("erd_ack",    {31'd0, err_rd_ack}, 32'd1);
        chk("erd_m1",     hrdata,    32'h12340000);
        chk("erd_m0",     hrdata_m0, 32'h00001234);
        @(negedge clk); #1;
        chk("erd_ack_off", {31'd0, err_rd_ack}, 32'd0);

        // Reset during a buffer wait state aborts the read
        @(negedge clk); ap(7'h08, 1'b0, 2'd0);
        @(negedge clk); idle(); #1;
        chk("abort_wait_rd_en", {31'd0, buf_rd_en}, 32'd1);
        nRst = 1'b0; #1;
        chk("abort_hready", {31'd0, hready}, 32'd1);
        chk("abort_hresp",  {31'd0, hresp},  32'd0);
        chk("abort_rd_en",  {31'd0, buf_rd_en}, 32'd0);
        chk("abort_hrdata", hrdata, 32'd0);
        chk("abort_ehts",   {24'd0, ehts}, 32'd0);
        @(negedge clk); #1;
        chk("abort_rd_en_hold", {31'd0, buf_rd_en}, 32'd0);
        nRst = 1'b1;
        @(negedge clk); #1;
        chk("abort_rd_en_after", {31'd0, buf_rd_en}, 32'd0);
        chk("abort_hready_after", {31'd0, hready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
